mode_counter: RTL and testbench

MODE_COUNTER -- requirements
Module: mode_counter

---
 rtl/counter_pkg.sv | 20 ++
 rtl/mode_counter_next.sv | 94 +++++++++
 rtl/mode_counter.sv | 103 ++++++++++
 tb/tb_mode_counter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : counter_pkg
//  Description : Shared constants for the mode_counter block: default data
//                width and the 2-bit operation (direction) encoding that the
//                top-level priority decoder hands to the next-value logic.
//  Revision    : 1.0 - initial release
// ============================================================================
package counter_pkg;

  localparam int DEFAULT_WIDTH = 16;

  // Operation selected for the current cycle after priority decode.
  localparam logic [1:0] HOLD = 2'd0;
  localparam logic [1:0] UP   = 2'd1;
  localparam logic [1:0] DOWN = 2'd2;
  localparam logic [1:0] LOAD = 2'd3;

endpackage : counter_pkg
`default_nettype wire

// File: rtl/mode_counter_next.sv
`default_nettype none
// ============================================================================
//  Module      : mode_counter_next
//  Description : Combinational next-count and boundary-crossing calculation.
//                All arithmetic is carried out in WIDTH+1 bits so that
//                out+step and limit+1 never lose a carry.
//  Ports       : dir       - selected operation (HOLD/UP/DOWN/LOAD)
//                cur       - current registered count
//                d_in      - load value
//                step      - count magnitude
//                limit     - inclusive upper bound of the count range
//                wrap_en   - 1 = modulo (limit+1), 0 = saturate
//                nxt       - next count value
//                cross_up  - upward boundary crossing this cycle
//                cross_dn  - downward boundary crossing this cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module mode_counter_next
  import counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [1:0]       dir,
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] d_in,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] limit,
  input  logic             wrap_en,
  output logic [WIDTH-1:0] nxt,
  output logic             cross_up,
  output logic             cross_dn
);

  localparam logic [WIDTH:0] c_one = {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH:0] w_cur_x;
  logic [WIDTH:0] w_step_x;
  logic [WIDTH:0] w_lim_x;
  logic [WIDTH:0] w_span;     // limit+1, number of legal values
  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_up_wrap;
  logic [WIDTH:0] w_dn_wrap;
  logic           w_step_big; // step larger than the whole range: clamp instead of wrap

  always_comb begin
    w_cur_x    = {1'b0, cur};
    w_step_x   = {1'b0, step};
    w_lim_x    = {1'b0, limit};
    w_span     = w_lim_x + c_one;
    w_sum      = w_cur_x + w_step_x;
    w_up_wrap  = w_sum - w_span;
    // Only used when step > cur, which keeps the result below span.
    w_dn_wrap  = w_cur_x + w_span - w_step_x;
    w_step_big = (w_step_x > w_span);

    nxt      = cur;
    cross_up = 1'b0;
    cross_dn = 1'b0;

    unique case (dir)
      LOAD: begin
        nxt = (d_in > limit) ? limit : d_in;
      end
      UP, DOWN: begin
        if (step == '0) begin
          nxt = cur;
        end else if (cur > limit) begin
          // Limit was lowered underneath the count: snap to the new bound.
          nxt      = limit;
          cross_up = 1'b1;
        end else if (dir == UP) begin
          if (w_sum <= w_lim_x) begin
            nxt = w_sum[WIDTH-1:0];
          end else begin
            cross_up = 1'b1;
            nxt      = (wrap_en && !w_step_big) ? w_up_wrap[WIDTH-1:0] : limit;
          end
        end else begin
          if (w_step_x <= w_cur_x) begin
            nxt = cur - step;
          end else begin
            cross_dn = 1'b1;
            nxt      = (wrap_en && !w_step_big) ? w_dn_wrap[WIDTH-1:0] : '0;
          end
        end
      end
      default: begin
        nxt = cur;
      end
    endcase
  end

endmodule : mode_counter_next
`default_nettype wire

// File: rtl/mode_counter.sv
`default_nettype none
// ============================================================================
//  Module      : mode_counter
//  Description : Up/down counter with programmable step and limit, modulo or
//                saturating boundary behaviour, terminal-count pulse and
//                sticky overflow/underflow flags.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                load, d_in          - load request and value
//                count_up/count_down - count requests
//                step, limit         - step magnitude, inclusive upper bound
//                wrap_en             - 1 = wrap, 0 = saturate
//                clr_flags           - clear sticky ovf/unf
//                out                 - registered count
//                at_zero, at_max     - combinational out==0 / out==limit
//                tc                  - one-cycle boundary-crossing pulse
//                ovf, unf            - sticky up/down crossing flags
//  Revision    : 1.0 - initial release
// ============================================================================
module mode_counter
  import counter_pkg::*;
#(
  parameter int               WIDTH   = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d_in,
  input  logic             count_up,
  input  logic             count_down,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] limit,
  input  logic             wrap_en,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] out,
  output logic             at_zero,
  output logic             at_max,
  output logic             tc,
  output logic             ovf,
  output logic             unf
);

  logic [WIDTH-1:0] r_out;
  logic             r_tc;
  logic             r_ovf;
  logic             r_unf;

  logic [1:0]       w_dir;
  logic [WIDTH-1:0] w_nxt;
  logic             w_cross_up;
  logic             w_cross_dn;
  logic [WIDTH-1:0] w_rst_val;

  // Priority decode: load beats counting; opposing requests cancel.
  always_comb begin
    w_dir = HOLD;
    if (load)                       w_dir = LOAD;
    else if (count_up && count_down) w_dir = HOLD;
    else if (count_up)              w_dir = UP;
    else if (count_down)            w_dir = DOWN;
  end

  // Reset value must also respect the current range.
  assign w_rst_val = (RST_VAL > limit) ? limit : RST_VAL;

  mode_counter_next #(
    .WIDTH (WIDTH)
  ) u_next (
    .dir      (w_dir),
    .cur      (r_out),
    .d_in     (d_in),
    .step     (step),
    .limit    (limit),
    .wrap_en  (wrap_en),
    .nxt      (w_nxt),
    .cross_up (w_cross_up),
    .cross_dn (w_cross_dn)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out <= w_rst_val;
      r_tc  <= 1'b0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_out <= w_nxt;
      r_tc  <= w_cross_up | w_cross_dn;
      // A crossing in the same cycle as a clear keeps the flag set.
      r_ovf <= w_cross_up | (r_ovf & ~clr_flags);
      r_unf <= w_cross_dn | (r_unf & ~clr_flags);
    end
  end

  assign out     = r_out;
  assign tc      = r_tc;
  assign ovf     = r_ovf;
  assign unf     = r_unf;
  assign at_zero = (r_out == '0);
  assign at_max  = (r_out == limit);

endmodule : mode_counter
`default_nettype wire

// File: tb/tb_mode_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mode_counter
//  Description : Self-checking bench for mode_counter (WIDTH=16, RST_VAL=5)
//                with directed scenarios and random stimulus compared against
//                an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mode_counter;

  localparam int          c_w   = 16;
  localparam logic [15:0] c_rst = 16'd5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] d_in = '0;
  logic        count_up = 1'b0;
  logic        count_down = 1'b0;
  logic [15:0] step = 16'd1;
  logic [15:0] limit = 16'd9;
  logic        wrap_en = 1'b0;
  logic        clr_flags = 1'b0;
  logic [15:0] out;
  logic        at_zero, at_max, tc, ovf, unf;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int m_out = 0;
  bit m_tc = 0, m_ovf = 0, m_unf = 0;

  mode_counter #(.WIDTH(c_w), .RST_VAL(c_rst)) u_dut (
    .clk(clk), .rst(rst), .load(load), .d_in(d_in),
    .count_up(count_up), .count_down(count_down), .step(step),
    .limit(limit), .wrap_en(wrap_en), .clr_flags(clr_flags),
    .out(out), .at_zero(at_zero), .at_max(at_max), .tc(tc),
    .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
    end
  endtask

  // Behavioural model: values live in 0..lim; a wrap is a modulo over lim+1 values.
  task automatic model_step();
    int lim, span, s;
    bit up_ev, dn_ev;
    lim   = int'(limit);
    span  = lim + 1;
    up_ev = 0;
    dn_ev = 0;
    if (rst) begin
      m_out = (int'(c_rst) > lim) ? lim : int'(c_rst);
      m_tc = 0; m_ovf = 0; m_unf = 0;
      return;
    end
    if (load) begin
      m_out = (int'(d_in) > lim) ? lim : int'(d_in);
    end else if (count_up != count_down && step != 0) begin
      if (m_out > lim) begin
        m_out = lim;
        up_ev = 1;
      end else if (count_up) begin
        s = m_out + int'(step);
        if (s <= lim) m_out = s;
        else begin
          up_ev = 1;
          m_out = (!wrap_en || int'(step) > span) ? lim : s % span;
        end
      end else begin
        s = m_out - int'(step);
        if (s >= 0) m_out = s;
        else begin
          dn_ev = 1;
          m_out = (!wrap_en || int'(step) > span) ? 0 : ((s % span) + span) % span;
        end
      end
    end
    m_tc  = up_ev | dn_ev;
    m_ovf = up_ev | (m_ovf & !clr_flags);
    m_unf = dn_ev | (m_unf & !clr_flags);
  endtask

  // Advance one clock with the current inputs and compare every output.
  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_eq({tag, ".out"},     int'(out),     m_out);
    check_eq({tag, ".tc"},      int'(tc),      int'(m_tc));
    check_eq({tag, ".ovf"},     int'(ovf),     int'(m_ovf));
    check_eq({tag, ".unf"},     int'(unf),     int'(m_unf));
    check_eq({tag, ".at_zero"}, int'(at_zero), int'(m_out == 0));
    check_eq({tag, ".at_max"},  int'(at_max),  int'(m_out == int'(limit)));
  endtask

  task automatic idle();
    rst = 0; load = 0; count_up = 0; count_down = 0; clr_flags = 0;
  endtask

  task automatic do_load(input logic [15:0] v, input string tag);
    idle(); load = 1; d_in = v; tick(tag); load = 0;
  endtask

  initial begin
    // reset state
    rst = 1; limit = 16'd9;
    tick("reset");
    check_eq("reset_val", int'(out), 5);

    // modulo wrap upward
    idle(); wrap_en = 1; step = 16'd3;
    do_load(16'd8, "w_ld8");
    count_up = 1; tick("wrap_up");
    check_eq("wrap_up_out", int'(out), 1);
    check_eq("wrap_up_ovf", int'(ovf), 1);
    count_up = 0; tick("wrap_up_tcoff");
    check_eq("tc_one_cycle", int'(tc), 0);

    // saturating downward, then again at the bound
    idle(); clr_flags = 1; tick("clr"); idle();
    wrap_en = 0; do_load(16'd2, "s_ld2");
    count_down = 1; tick("sat_dn1");
    check_eq("sat_dn_unf", int'(unf), 1);
    tick("sat_dn2");
    check_eq("sat_dn2_tc", int'(tc), 1);
    check_eq("sat_dn2_out", int'(out), 0);

    // load clamp
    idle(); limit = 16'h00FF; do_load(16'h1234, "ld_clamp");
    check_eq("ld_clamp_out", int'(out), 16'h00FF);

    // opposing requests hold; set beats clear
    limit = 16'd9; idle(); clr_flags = 1; tick("clr2");
    do_load(16'd5, "h_ld5");
    count_up = 1; count_down = 1; step = 16'd3; tick("both");
    check_eq("both_out", int'(out), 5);
    count_down = 0; step = 16'd9; clr_flags = 1; tick("set_vs_clr");
    check_eq("set_vs_clr_ovf", int'(ovf), 1);

    // full-range natural wrap
    idle(); wrap_en = 1; limit = 16'hFFFF; step = 16'd1;
    do_load(16'hFFFF, "f_ld");
    count_up = 1; tick("full_wrap");
    check_eq("full_wrap_zero", int'(at_zero), 1);

    // limit lowered under count, then reset mid-count
    idle(); limit = 16'd9; do_load(16'd7, "l_ld7");
    limit = 16'd4; count_down = 1; step = 16'd1; tick("lim_low");
    check_eq("lim_low_out", int'(out), 4);
    limit = 16'd9; count_up = 1; count_down = 0; rst = 1; tick("mid_rst");
    rst = 0; tick("after_rst");
    check_eq("after_rst_out", int'(out), 6);

    // step zero holds, oversize step with wrap clamps
    idle(); step = 16'd0; count_up = 1; tick("step0");
    step = 16'd20; wrap_en = 1; tick("big_up");
    count_up = 0; count_down = 1; tick("big_dn");

    // random stimulus
    for (int i = 0; i < 4000; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      load      = ($urandom_range(0, 9) == 0);
      d_in      = 16'($urandom);
      count_up  = ($urandom_range(0, 2) != 0);
      count_down = ($urandom_range(0, 2) != 0);
      wrap_en   = 1'($urandom);
      clr_flags = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 5))
          0: limit = 16'd0;
          1: limit = 16'd1;
          2: limit = 16'd9;
          3: limit = 16'h00FF;
          4: limit = 16'hFFFF;
          default: limit = 16'($urandom);
        endcase
      end
      case ($urandom_range(0, 3))
        0: step = 16'($urandom_range(0, 3));
        1: step = 16'($urandom_range(0, int'(limit) + 2));
        2: step = 16'($urandom);
        default: step = 16'd1;
      endcase
      tick("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_mode_counter
`default_nettype wire
